// File: rtl/mcs4_pkg.sv
// mcs4: shared MCS-4 types, with the ROM loader state encoding and the NOP opcode.
package mcs4;
  typedef logic [3:0] char_t;
  typedef enum logic [2:0] {HDR, DATA, CKSUM, FILL, HOLD, DONE, ERR} loader_state_t;
  localparam logic [7:0] MCS4_NOP = 8'h00;
endpackage

// File: rtl/mcs4_rom_loader_if.sv
// mcs4_rom_loader_if: byte stream in, ROM write port out; master = host side, slave = loader side.
interface mcs4_rom_loader_if #(parameter int ADDR_W = 8, parameter int DATA_W = 8);
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_wdata;
  modport master (output s_valid, s_data, input s_ready, rom_we, rom_addr, rom_wdata);
  modport slave  (input s_valid, s_data, output s_ready, rom_we, rom_addr, rom_wdata);
endinterface

// File: rtl/mcs4_rom_loader.sv
// mcs4_rom_loader: loads a framed image into i4001 ROM, NOP-fills the rest, then releases sys_rst.
// Define MCS4_LOADER_CKSUM_EN to require a trailing checksum byte (bad sum -> ERR).
module mcs4_rom_loader
  import mcs4::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_req,
  mcs4_rom_loader_if.slave    bus,
  output logic                sys_rst,
  output logic                load_done,
  output logic                load_err
);
  loader_state_t     state_q, state_d, fill_or_hold, after_data;
  logic [ADDR_W-1:0] addr_q, addr_d, cnt_q, cnt_d, rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0] rom_wdata_q, rom_wdata_d;
  logic [7:0]        sum_q, sum_d, hold_q, hold_d;
  logic              rom_we_q, rom_we_d, xfer;
  // A full-depth image leaves nothing to fill.
  assign fill_or_hold = (&cnt_q) ? HOLD : FILL;
`ifdef MCS4_LOADER_CKSUM_EN
  assign after_data = CKSUM;
  assign load_err   = state_q == ERR;
`else
  assign after_data = fill_or_hold;
  assign load_err   = 1'b0;
`endif
  assign bus.s_ready   = (state_q == HDR) || (state_q == DATA) || (state_q == CKSUM);
  assign xfer          = bus.s_valid && bus.s_ready;
  assign sys_rst       = state_q != DONE;
  assign load_done     = state_q == DONE;
  assign bus.rom_we    = rom_we_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.rom_wdata = rom_wdata_q;
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    hold_d      = '0;
    rom_we_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_wdata_d = rom_wdata_q;
    case (state_q)
      HDR: if (xfer) begin
        cnt_d   = ADDR_W'(bus.s_data);
        addr_d  = '0;
        sum_d   = '0;
        state_d = DATA;
      end
      DATA: if (xfer) begin
        rom_we_d    = 1'b1;
        rom_addr_d  = addr_q;
        rom_wdata_d = DATA_W'(bus.s_data);
        addr_d      = addr_q + 1'b1;
        sum_d       = sum_q + bus.s_data;
        if (addr_q == cnt_q) state_d = after_data;
      end
      FILL: begin
        rom_we_d    = 1'b1;
        rom_addr_d  = addr_q;
        rom_wdata_d = DATA_W'(MCS4_NOP);
        addr_d      = addr_q + 1'b1;
        if (&addr_q) state_d = HOLD;
      end
      HOLD: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == 8'(HOLD_CYCLES - 1)) state_d = DONE;
      end
      DONE: if (load_req) state_d = HDR;
`ifdef MCS4_LOADER_CKSUM_EN
      CKSUM: if (xfer) state_d = (8'(sum_q + bus.s_data) == 8'h00) ? fill_or_hold : ERR;
      ERR: if (load_req) state_d = HDR;
`endif
      default: state_d = HDR;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= HDR;
      addr_q      <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      hold_q      <= '0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      hold_q      <= hold_d;
      rom_we_q    <= rom_we_d;
      rom_addr_q  <= rom_addr_d;
      rom_wdata_q <= rom_wdata_d;
    end
  end
endmodule

// File: tb/tb_mcs4_rom_loader.sv
// tb_mcs4_rom_loader: scoreboard bench for the ROM loader; expected writes queued at stimulus time.
module tb_mcs4_rom_loader;
  logic clk = 1'b0, rst = 1'b0, load_req = 1'b0;
  logic sys_rst, load_done, load_err;
  mcs4_rom_loader_if #(.ADDR_W(8), .DATA_W(8)) bif ();
  mcs4_rom_loader #(.ADDR_W(8), .DATA_W(8), .HOLD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .bus(bif),
    .sys_rst(sys_rst), .load_done(load_done), .load_err(load_err)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_err = 0, cyc = 0, n_writes = 0, last_we_cyc = 0;
  int dc, rdy, w0;
  logic [15:0] exp_q[$], got_q[$];
  logic [15:0] e, g;
  logic [7:0]  frame[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bif.rom_we) begin
    got_q.push_back({bif.rom_addr, bif.rom_wdata});
    n_writes++;
    last_we_cyc = cyc;
  end
  task automatic send(input logic [7:0] b);
    int k = 0;
    bif.s_valid = 1'b1;
    bif.s_data  = b;
    @(negedge clk);
    while (!bif.s_ready && k < 50) begin @(negedge clk); k++; end
    if (k == 50) begin n_cmp++; n_err++; $display("FAIL send_timeout s_ready=0 required=1"); end
    @(posedge clk); #1;
    bif.s_valid = 1'b0;
  endtask
  task automatic load_frame(input int gap, input bit fill);
    send(8'(frame.size() - 1));
    foreach (frame[i]) begin
      exp_q.push_back({8'(i), frame[i]});
      send(frame[i]);
      repeat (gap) begin @(posedge clk); #1; end
    end
    if (fill) for (int a = frame.size(); a < 256; a++) exp_q.push_back({8'(a), 8'h00});
  endtask
  task automatic wait_done(output int dcyc, output int nrdy);
    int k = 0;
    nrdy = 0;
    @(negedge clk);
    while (!load_done && k < 2000) begin
      if (bif.s_ready) nrdy++;
      @(negedge clk);
      k++;
    end
    dcyc = load_done ? cyc : -1000;
    @(posedge clk); #1;
  endtask
  task automatic pulse_load_req();
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b0; bif.s_valid = 1'b0; bif.s_data = 8'h00;
    repeat (3) @(posedge clk); #1;
    n_cmp++;
    if ({bif.rom_we, bif.rom_addr, bif.rom_wdata, sys_rst, load_done, load_err} !== {1'b0, 8'h00, 8'h00, 3'b100}) begin
      n_err++;
      $display("FAIL reset_outputs got we=%b a=%h d=%h sr=%b dn=%b er=%b required 0/00/00/1/0/0",
               bif.rom_we, bif.rom_addr, bif.rom_wdata, sys_rst, load_done, load_err);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (bif.s_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b required 1", bif.s_ready); end
  endtask
  task automatic test_basic();
    exp_q.delete(); got_q.delete(); w0 = n_writes;
    frame = '{8'hD5, 8'hB2, 8'h00};
    load_frame(0, 1'b1);
    wait_done(dc, rdy);
    n_cmp++; if (dc - last_we_cyc !== 4) begin n_err++; $display("FAIL basic_hold got %0d required 4", dc - last_we_cyc); end
    n_cmp++; if ({sys_rst, load_done, load_err} !== 3'b010) begin n_err++; $display("FAIL basic_done got %b required 010", {sys_rst, load_done, load_err}); end
    n_cmp++; if (n_writes - w0 !== 256) begin n_err++; $display("FAIL basic_nwrites got %0d required 256", n_writes - w0); end
    n_cmp++; if (rdy !== 0) begin n_err++; $display("FAIL basic_ready got %0d required 0", rdy); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL basic_write got %h required %h", g, e); end
    end
    n_cmp++; if (exp_q.size() != got_q.size()) begin n_err++; $display("FAIL basic_left exp=%0d got=%0d required 0/0", exp_q.size(), got_q.size()); end
  endtask
  task automatic test_gaps();
    pulse_load_req();
    exp_q.delete(); got_q.delete(); w0 = n_writes;
    frame = '{8'hD5, 8'hB2, 8'h00};
    load_frame(2, 1'b1);
    wait_done(dc, rdy);
    n_cmp++; if (dc - last_we_cyc !== 4) begin n_err++; $display("FAIL gaps_hold got %0d required 4", dc - last_we_cyc); end
    n_cmp++; if (n_writes - w0 !== 256) begin n_err++; $display("FAIL gaps_nwrites got %0d required 256", n_writes - w0); end
    n_cmp++; if (rdy !== 0) begin n_err++; $display("FAIL gaps_ready got %0d required 0", rdy); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL gaps_write got %h required %h", g, e); end
    end
    n_cmp++; if (exp_q.size() != got_q.size()) begin n_err++; $display("FAIL gaps_left exp=%0d got=%0d required 0/0", exp_q.size(), got_q.size()); end
  endtask
  task automatic test_full();
    pulse_load_req();
    exp_q.delete(); got_q.delete(); w0 = n_writes;
    frame.delete();
    for (int i = 0; i < 256; i++) frame.push_back(8'(i));
    load_frame(0, 1'b1);
    wait_done(dc, rdy);
    n_cmp++; if (dc - last_we_cyc !== 4) begin n_err++; $display("FAIL full_hold got %0d required 4", dc - last_we_cyc); end
    n_cmp++; if (n_writes - w0 !== 256) begin n_err++; $display("FAIL full_nwrites got %0d required 256", n_writes - w0); end
    n_cmp++; if (load_done !== 1'b1) begin n_err++; $display("FAIL full_done got %b required 1", load_done); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL full_write got %h required %h", g, e); end
    end
    n_cmp++; if (exp_q.size() != got_q.size()) begin n_err++; $display("FAIL full_left exp=%0d got=%0d required 0/0", exp_q.size(), got_q.size()); end
  endtask
`ifdef MCS4_LOADER_CKSUM_EN
  task automatic test_cksum();
    pulse_load_req();
    exp_q.delete(); got_q.delete();
    frame = '{8'hD5, 8'hB2, 8'h00};
    load_frame(0, 1'b1);
    send(8'h79);
    wait_done(dc, rdy);
    n_cmp++; if ({sys_rst, load_done, load_err} !== 3'b010) begin n_err++; $display("FAIL cksum_good got %b required 010", {sys_rst, load_done, load_err}); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL cksum_write got %h required %h", g, e); end
    end
    n_cmp++; if (exp_q.size() != got_q.size()) begin n_err++; $display("FAIL cksum_left exp=%0d got=%0d required 0/0", exp_q.size(), got_q.size()); end
    pulse_load_req();
    exp_q.delete(); got_q.delete();
    load_frame(0, 1'b0);
    send(8'h78);
    repeat (20) @(posedge clk); #1;
    n_cmp++; if ({sys_rst, load_done, load_err} !== 3'b101) begin n_err++; $display("FAIL cksum_bad got %b required 101", {sys_rst, load_done, load_err}); end
    n_cmp++; if (bif.s_ready !== 1'b0) begin n_err++; $display("FAIL cksum_err_ready got %b required 0", bif.s_ready); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL cksum_bad_write got %h required %h", g, e); end
    end
    n_cmp++; if (exp_q.size() != got_q.size()) begin n_err++; $display("FAIL cksum_bad_left exp=%0d got=%0d required 0/0", exp_q.size(), got_q.size()); end
    pulse_load_req();
    n_cmp++; if ({load_err, bif.s_ready} !== 2'b01) begin n_err++; $display("FAIL cksum_recover got %b required 01", {load_err, bif.s_ready}); end
  endtask
`endif
  task automatic test_mid_reset();
    pulse_load_req();
    exp_q.delete(); got_q.delete();
    send(8'h02);
    exp_q.push_back({8'h00, 8'hD5}); send(8'hD5);
    exp_q.push_back({8'h01, 8'hB2}); send(8'hB2);
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({bif.rom_we, bif.rom_addr, bif.rom_wdata, sys_rst, load_done, load_err} !== {1'b0, 8'h00, 8'h00, 3'b100}) begin
      n_err++;
      $display("FAIL midrst_outputs got we=%b a=%h d=%h sr=%b dn=%b er=%b required 0/00/00/1/0/0",
               bif.rom_we, bif.rom_addr, bif.rom_wdata, sys_rst, load_done, load_err);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL midrst_write got %h required %h", g, e); end
    end
    n_cmp++; if (exp_q.size() != got_q.size()) begin n_err++; $display("FAIL midrst_left exp=%0d got=%0d required 0/0", exp_q.size(), got_q.size()); end
    rst = 1'b1;
    @(posedge clk); #1;
    frame = '{8'h11, 8'h22, 8'h33, 8'h44};
    load_frame(0, 1'b1);
    wait_done(dc, rdy);
    n_cmp++; if (load_done !== 1'b1) begin n_err++; $display("FAIL midrst_done got %b required 1", load_done); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL midrst_reload got %h required %h", g, e); end
    end
    n_cmp++; if (exp_q.size() != got_q.size()) begin n_err++; $display("FAIL midrst_reload_left exp=%0d got=%0d required 0/0", exp_q.size(), got_q.size()); end
  endtask
  task automatic test_load_req();
    exp_q.delete(); got_q.delete(); w0 = n_writes;
    pulse_load_req();
    n_cmp++; if ({sys_rst, load_done, bif.s_ready} !== 3'b101) begin n_err++; $display("FAIL loadreq_restart got %b required 101", {sys_rst, load_done, bif.s_ready}); end
    frame = '{8'h20};
    load_frame(0, 1'b1);
    wait_done(dc, rdy);
    n_cmp++; if (dc - last_we_cyc !== 4) begin n_err++; $display("FAIL loadreq_hold got %0d required 4", dc - last_we_cyc); end
    n_cmp++; if (n_writes - w0 !== 256) begin n_err++; $display("FAIL loadreq_nwrites got %0d required 256", n_writes - w0); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL loadreq_write got %h required %h", g, e); end
    end
    n_cmp++; if (exp_q.size() != got_q.size()) begin n_err++; $display("FAIL loadreq_left exp=%0d got=%0d required 0/0", exp_q.size(), got_q.size()); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_full();
`ifdef MCS4_LOADER_CKSUM_EN
    test_cksum();
`endif
    test_mid_reset();
    test_load_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/mcs4_rom_loader.md
Name: mcs4_rom_loader

Overview:
- Upstream boot stage for the MCS-4 system: accepts a framed byte stream and writes it into i4001 program memory through a simple write port.
- Holds the CPU, ROM and RAM in reset while loading. Zero-fills unused ROM with NOP (00).
- Releases system reset once the image is in place, so a bench or PYNQ host can boot programs such as "LDM 5 / XCH R2 / NOP" (D5 B2 00).

Parameters:
- ADDR_W, 8, ROM address width; depth = 2**ADDR_W.
- DATA_W, 8, ROM word width (one 4004 instruction byte).
- HOLD_CYCLES, 4, cycles sys_rst stays asserted after the last ROM write; range 1..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset (0 = reset).
- load_req  in  1  single-cycle pulse; restarts loading from DONE or ERR.
- s_valid  in  1  stream byte valid.
- s_data  in  8  stream byte.
- s_ready  out  1  loader accepts the byte this cycle.
- rom_we  out  1  ROM write strobe.
- rom_addr  out  ADDR_W  ROM write address.
- rom_wdata  out  DATA_W  ROM write data.
- sys_rst  out  1  active-high reset to i4004/i4001/i4002.
- load_done  out  1  image loaded and system running.
- load_err  out  1  frame rejected.

Behaviour:
- Frame format: byte0 = LEN_M1 (N = LEN_M1+1, range 1..2**ADDR_W); then N data bytes written to addresses 0..N-1; then one checksum byte only if the optional feature is enabled.
- Handshake: a byte transfers when s_valid && s_ready. s_ready is combinational from state and is 1 only in HDR, DATA and CKSUM. s_data is ignored otherwise.
- Reset (rst==0):
  - state=HDR, addr=0, sum=0.
  - rom_we=0, rom_addr=0, rom_wdata=0.
  - sys_rst=1, load_done=0, load_err=0.
  - Reset mid-load abandons the frame; ROM contents already written are left as-is.
- HDR: on transfer, latch cnt=LEN_M1, addr=0, sum=0, then go to DATA.
- DATA: each transfer registers rom_we=1, rom_addr=addr, rom_wdata=s_data on the next cycle (1-cycle latency), then addr++ and sum+=s_data (mod 256).
  - After the transfer with addr==cnt: go to CKSUM if enabled, else FILL.
  - s_valid gaps give rom_we=0 on those cycles.
- FILL: write 00 to addr, one per cycle, for addr = N..2**ADDR_W-1. Go to HOLD after the write to the top address.
  - If N == 2**ADDR_W, skip FILL and go straight to HOLD.
- HOLD: sys_rst=1; count HOLD_CYCLES cycles, then go to DONE.
- DONE: sys_rst=0, load_done=1, s_ready=0.
  - load_req: next cycle sys_rst=1, load_done=0, state=HDR.
- ERR: load_err=1, sys_rst=1, s_ready=0.
  - load_req: clear load_err, go to HDR.
- load_req is ignored in HDR, DATA, CKSUM, FILL and HOLD.
- rom_we is 0 in every state except the cycle after a DATA transfer and FILL cycles.
- Address arithmetic wraps at 2**ADDR_W. A top-address write ends the phase; there is never a second write to address 0.

Optional Feature:
- Macro MCS4_LOADER_CKSUM_EN.
- Defined: CKSUM state accepts one byte.
  - (sum + byte) mod 256 == 0 -> FILL.
  - Otherwise -> ERR. No FILL is done; data already written stays in ROM.
- Undefined: no CKSUM state; load_err is tied 0 and the ERR state is absent.

Decomposition:
- Shared package mcs4: add loader_state_t enum (HDR, DATA, CKSUM, FILL, HOLD, DONE, ERR) and constant MCS4_NOP = 8'h00.
- Use the existing mcs4::char_t wherever 4-bit nibbles are referenced.
- No sub-module; single FSM plus address, checksum and hold counters.

Test Plan:
- Stream 02,D5,B2,00 with s_valid held high.
  - Expect ROM writes 0:D5, 1:B2, 2:00, then 3..255 = 00, one per cycle.
  - sys_rst falls HOLD_CYCLES=4 cycles after the addr-255 write; load_done=1.
  - With the CPU attached, R2 == 5.
- Same frame with s_valid toggling 1,0,0,1 between bytes -> identical ROM image; rom_we pulses only after accepted bytes; s_ready=0 throughout FILL/HOLD.
- LEN_M1=FF with 256 bytes i[7:0] -> addr i gets i; no FILL cycles; exactly 256 writes; HOLD, then DONE.
- CKSUM_EN: frame 02,D5,B2,00,79 -> DONE. Same frame with checksum 78 -> load_err=1, sys_rst=1, no FILL writes; load_req then returns to HDR with load_err=0.
- Assert rst=0 after the second data byte -> all outputs take reset values next cycle. A fresh frame then loads correctly from address 0.
- In DONE, pulse load_req -> sys_rst=1 and load_done=0 next cycle; new frame 00,20 loads with addr0=20 and 1..255=00.
